// File: rtl/ex_sched.sv
// ex_sched: execute-stage hazard scheduler for a 5-stage pipeline.
// Generates load-use stalls, taken-branch flushes, the halt/drain
// sequence and the ALU operand forwarding selects.
// Optional build macro EX_SCHED_STATS_EN adds stall/flush cycle counters
// (stallCnt, flushCnt); without it those ports do not exist.
module ex_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rs_ID,
  input  logic [3:0] rt_ID,
  input  logic       useRs_ID,
  input  logic       useRt_ID,
  input  logic [3:0] rd_EX,
  input  logic       regWrite_EX,
  input  logic       memRead_EX,
  input  logic [3:0] rd_MEM,
  input  logic       regWrite_MEM,
  input  logic [3:0] rs_EX,
  input  logic [3:0] rt_EX,
  input  logic       branchTaken_EX,
  input  logic       halt_ID,
  output logic       stallPC,
  output logic       stallIFID,
  output logic       flushIDEX,
  output logic       flushIFID,
  output logic [1:0] fwdA,
  output logic [1:0] fwdB,
  output logic       halted
`ifdef EX_SCHED_STATS_EN
  ,
  output logic [15:0] stallCnt,
  output logic [15:0] flushCnt
`endif
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    LDSTALL = 3'd1,
    BRFLUSH = 3'd2,
    DRAIN   = 3'd3,
    HALTED  = 3'd4
  } state_t;

  localparam logic [3:0] DRAIN_CYCLES = 4'd3;

  state_t     state, state_nxt;
  logic [3:0] drain_cnt, drain_cnt_nxt;
  logic [3:0] wb_rd;
  logic       wb_we;
  logic       load_use;

  // Load in EX whose destination is read by the instruction in ID.
  assign load_use = memRead_EX && regWrite_EX && (rd_EX != 4'd0) &&
                    ((useRs_ID && (rs_ID == rd_EX)) ||
                     (useRt_ID && (rt_ID == rd_EX)));

  // State, drain counter and WB-stage destination registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      drain_cnt <= 4'd0;
      wb_rd     <= 4'd0;
      wb_we     <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      wb_rd     <= rd_MEM;
      wb_we     <= regWrite_MEM;
    end
  end

  // Next-state and pipeline control outputs; branch beats load-use beats halt.
  // NOTE: every variable gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    stallPC       = 1'b0;
    stallIFID     = 1'b0;
    flushIDEX     = 1'b0;
    flushIFID     = 1'b0;
    halted        = 1'b0;
    case (state)
      RUN: begin
        if (branchTaken_EX) begin
          flushIFID = 1'b1;
          flushIDEX = 1'b1;
          state_nxt = BRFLUSH;
        end else if (load_use) begin
          stallPC   = 1'b1;
          stallIFID = 1'b1;
          flushIDEX = 1'b1;
          state_nxt = LDSTALL;
        end else if (halt_ID) begin
          stallPC       = 1'b1;
          drain_cnt_nxt = DRAIN_CYCLES;
          state_nxt     = DRAIN;
        end
      end
      LDSTALL: begin
        if (branchTaken_EX) begin
          flushIFID = 1'b1;
          flushIDEX = 1'b1;
          state_nxt = BRFLUSH;
        end else begin
          state_nxt = RUN;
        end
      end
      BRFLUSH: state_nxt = RUN;
      DRAIN: begin
        if (branchTaken_EX) begin
          // A taken branch ahead of the HLT means the HLT was wrong-path.
          flushIFID     = 1'b1;
          flushIDEX     = 1'b1;
          drain_cnt_nxt = 4'd0;
          state_nxt     = BRFLUSH;
        end else begin
          stallPC   = 1'b1;
          flushIFID = 1'b1;
          if (drain_cnt == 4'd1) begin
            drain_cnt_nxt = 4'd0;
            state_nxt     = HALTED;
          end else begin
            drain_cnt_nxt = drain_cnt - 4'd1;
          end
        end
      end
      HALTED: begin
        halted    = 1'b1;
        stallPC   = 1'b1;
        stallIFID = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
    // Outputs are forced low for the whole reset pulse, not just after an edge.
    if (rst) begin
      stallPC   = 1'b0;
      stallIFID = 1'b0;
      flushIDEX = 1'b0;
      flushIFID = 1'b0;
      halted    = 1'b0;
    end
  end

  // Forwarding selects: MEM result first, then WB result, never register 0.
  always_comb begin
    fwdA = 2'b00;
    fwdB = 2'b00;
    if (!rst) begin
      if (regWrite_MEM && (rd_MEM != 4'd0) && (rd_MEM == rs_EX))
        fwdA = 2'b01;
      else if (wb_we && (wb_rd != 4'd0) && (wb_rd == rs_EX))
        fwdA = 2'b10;
      if (regWrite_MEM && (rd_MEM != 4'd0) && (rd_MEM == rt_EX))
        fwdB = 2'b01;
      else if (wb_we && (wb_rd != 4'd0) && (wb_rd == rt_EX))
        fwdB = 2'b10;
    end
  end

`ifdef EX_SCHED_STATS_EN
  // Saturating counters of stalled-IFID and flushed-IDEX cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= 16'd0;
      flushCnt <= 16'd0;
    end else begin
      if (stallIFID && (stallCnt != 16'hFFFF)) stallCnt <= stallCnt + 16'd1;
      if (flushIDEX && (flushCnt != 16'hFFFF)) flushCnt <= flushCnt + 16'd1;
    end
  end
`endif

endmodule
